// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, pipeline latency and FIPS-197 reference vectors.
package aes_pkg;
    localparam int AES_LATENCY = 10;
    typedef logic [127:0] aes_block_t;
    localparam aes_block_t FIPS_KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam aes_block_t FIPS_PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam aes_block_t FIPS_CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam aes_block_t FIPS_KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam aes_block_t FIPS_PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam aes_block_t FIPS_CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
endpackage

// File: rtl/aes_out_fifo.sv
// aes_out_fifo: single-clock show-ahead FIFO capturing ciphertext from the AES pipeline.
module aes_out_fifo
    import aes_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  aes_block_t               wr_data,
    output aes_block_t               rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    aes_block_t mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    assign empty = count == '0;
    assign rd_data = empty ? '0 : mem[rdPtr];
    always_ff @(posedge clk) begin
        if (wr_en) mem[wrPtr] <= wr_data;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            // The pipeline cannot stall, so a write into a full FIFO would lose a block.
            assert (!wr_en || count != (AW+1)'(DEPTH)) else $error("aes_out_fifo overflow");
            if (wr_en) wrPtr <= wrPtr + 1'b1;
            if (rd_en) rdPtr <= rdPtr + 1'b1;
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end
endmodule

// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: valid/ready front end for a stall-free AES-128 pipeline,
// tracking slots with a tag shift register and throttling input by FIFO credit.
module aes_stream_ctrl
    import aes_pkg::*;
#(
    parameter int LATENCY    = AES_LATENCY,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_load,
    input  aes_block_t key_in,
    input  logic       s_valid,
    output logic       s_ready,
    input  aes_block_t s_data,
    output logic       m_valid,
    input  logic       m_ready,
    output aes_block_t m_data,
    output logic       busy,
    output aes_block_t aes_key,
    output aes_block_t aes_plaintext,
    input  aes_block_t aes_ciphertext
);
    localparam int IW = $clog2(LATENCY + 2);
    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = FW + 1;
    logic keyValid, hs, fifoWr, pop, fifoEmpty;
    aes_block_t keyReg, ptReg;
    logic [LATENCY:0] tagReg;
    logic [IW-1:0] inflightCnt;
    logic [FW-1:0] fifoCnt;
    logic [CW-1:0] creditUsed;
    // Every block in flight has a reserved FIFO slot, so writes can never overflow.
    assign creditUsed = CW'(inflightCnt) + CW'(fifoCnt);
    assign s_ready = keyValid && (creditUsed < CW'(FIFO_DEPTH));
    assign hs = s_valid && s_ready;
    assign fifoWr = tagReg[LATENCY];
    assign m_valid = !fifoEmpty;
    assign pop = m_valid && m_ready;
    assign busy = (inflightCnt != '0) || (fifoCnt != '0);
    assign aes_key = keyReg;
    assign aes_plaintext = ptReg;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            keyValid    <= 1'b0;
            keyReg      <= '0;
            ptReg       <= '0;
            tagReg      <= '0;
            inflightCnt <= '0;
        end else begin
            if (key_load) begin
                keyReg   <= key_in;
                keyValid <= 1'b1;
            end
            if (hs) ptReg <= s_data;
            tagReg      <= {tagReg[LATENCY-1:0], hs};
            inflightCnt <= inflightCnt + IW'(hs) - IW'(fifoWr);
        end
    end
    aes_out_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (fifoWr),
        .rd_en  (pop),
        .wr_data(aes_ciphertext),
        .rd_data(m_data),
        .empty  (fifoEmpty),
        .count  (fifoCnt)
    );
endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb_aes_stream_ctrl: directed bench with a behavioural AES pipeline stand-in
// that returns FIPS-197 ciphertexts for the reference vectors.
module tb_aes_stream_ctrl;
    import aes_pkg::*;
    logic clk = 1'b0, rst_n, key_load, s_valid, s_ready, m_valid, m_ready, busy;
    aes_block_t key_in, s_data, m_data, aes_key, aes_plaintext, aes_ciphertext;
    aes_block_t stg [1:AES_LATENCY];
    aes_block_t q [$];
    aes_block_t res [2];
    int errs = 0, checks = 0;
    int sent, got, firstHs, firstRx, lastRx;
    logic flag;

    aes_stream_ctrl dut (
        .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy),
        .aes_key(aes_key), .aes_plaintext(aes_plaintext), .aes_ciphertext(aes_ciphertext)
    );

    always #5 clk = ~clk;

    function automatic aes_block_t model(aes_block_t k, aes_block_t p);
        if (k == FIPS_KEY_A && p == FIPS_PT_A) return FIPS_CT_A;
        if (k == FIPS_KEY_B && p == FIPS_PT_B) return FIPS_CT_B;
        return p ^ {k[63:0], k[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
    endfunction

    function automatic aes_block_t ptGen(int i);
        return {4{32'(i) * 32'h9e3779b9 + 32'h1234}};
    endfunction

    always @(posedge clk) begin
        stg[1] <= model(aes_key, aes_plaintext);
        for (int k = 2; k <= AES_LATENCY; k++) stg[k] <= stg[k-1];
    end
    assign aes_ciphertext = stg[AES_LATENCY];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; key_load = 1'b0; key_in = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        tick(); tick();
        chk("rst_s_ready", 128'(s_ready), 128'(0));
        chk("rst_m_valid", 128'(m_valid), 128'(0));
        chk("rst_m_data", m_data, '0);
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_aes_key", aes_key, '0);
        chk("rst_aes_pt", aes_plaintext, '0);
        rst_n = 1'b1;
        // s_valid without a key must not be accepted
        s_valid = 1'b1; s_data = FIPS_PT_A;
        tick(); tick(); tick();
        chk("nokey_s_ready", 128'(s_ready), 128'(0));
        chk("nokey_busy", 128'(busy), 128'(0));
        key_load = 1'b1; key_in = FIPS_KEY_A;
        tick();
        key_load = 1'b0;
        chk("key_s_ready", 128'(s_ready), 128'(1));
        chk("key_aes_key", aes_key, FIPS_KEY_A);
        // single FIPS block, handshake on the next edge
        tick();
        s_valid = 1'b0;
        chk("single_aes_pt", aes_plaintext, FIPS_PT_A);
        flag = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            flag |= m_valid;
            if (i == 5) chk("single_busy", 128'(busy), 128'(1));
        end
        chk("single_early_m_valid", 128'(flag), 128'(0));
        tick();
        chk("single_m_valid_11", 128'(m_valid), 128'(1));
        chk("single_m_data", m_data, FIPS_CT_A);
        tick();
        chk("single_hold_m_data", m_data, FIPS_CT_A);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("single_drained", 128'(m_valid), 128'(0));
        chk("single_idle", 128'(busy), 128'(0));
        // 32 back-to-back blocks with m_ready held high
        m_ready = 1'b1; sent = 0; got = 0; firstHs = -1; firstRx = -1; lastRx = -1; flag = 1'b0;
        for (int n = 0; n < 80 && got < 32; n++) begin
            s_valid = sent < 32; s_data = ptGen(sent);
            if (m_valid) begin
                chk("b2b_data", m_data, q.pop_front());
                if (firstRx < 0) firstRx = n;
                lastRx = n; got++;
            end
            if (s_valid && !s_ready) flag = 1'b1;
            if (s_valid && s_ready) begin
                q.push_back(model(FIPS_KEY_A, s_data));
                if (firstHs < 0) firstHs = n + 1;
                sent++;
            end
            tick();
        end
        s_valid = 1'b0;
        chk("b2b_count", 128'(got), 128'(32));
        chk("b2b_no_stall", 128'(flag), 128'(0));
        chk("b2b_latency", 128'(firstRx - firstHs), 128'(11));
        chk("b2b_rate", 128'(lastRx - firstRx), 128'(31));
        // backpressure: exactly FIFO_DEPTH blocks accepted
        m_ready = 1'b0; sent = 0; q.delete();
        for (int n = 0; n < 40; n++) begin
            s_valid = 1'b1; s_data = ptGen(100 + sent);
            if (s_ready) begin
                q.push_back(model(FIPS_KEY_A, s_data));
                sent++;
            end
            tick();
        end
        s_valid = 1'b0;
        chk("bp_accepted", 128'(sent), 128'(16));
        chk("bp_s_ready_low", 128'(s_ready), 128'(0));
        chk("bp_m_valid", 128'(m_valid), 128'(1));
        m_ready = 1'b1; got = 0;
        chk("bp_s_ready_before_pop", 128'(s_ready), 128'(0));
        chk("bp_first_data", m_data, q.pop_front());
        got++;
        tick();
        chk("bp_s_ready_after_pop", 128'(s_ready), 128'(1));
        for (int n = 0; n < 30 && m_valid; n++) begin
            chk("bp_drain_data", m_data, q.pop_front());
            got++;
            tick();
        end
        chk("bp_drained", 128'(got), 128'(16));
        chk("bp_idle", 128'(busy), 128'(0));
        // key change on the same edge as a handshake
        chk("kc_s_ready", 128'(s_ready), 128'(1));
        s_valid = 1'b1; s_data = FIPS_PT_A;
        tick();
        s_data = FIPS_PT_B; key_load = 1'b1; key_in = FIPS_KEY_B;
        tick();
        s_valid = 1'b0; key_load = 1'b0;
        got = 0;
        for (int n = 0; n < 20 && got < 2; n++) begin
            if (m_valid) begin
                res[got] = m_data;
                got++;
            end
            tick();
        end
        chk("kc_count", 128'(got), 128'(2));
        chk("kc_old_key", res[0], FIPS_CT_A);
        chk("kc_new_key", res[1], FIPS_CT_B);
        // reset with 5 blocks in flight and 3 in the FIFO
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_data = ptGen(200 + i);
            tick();
        end
        s_valid = 1'b0;
        repeat (6) tick();
        chk("pre_rst_m_valid", 128'(m_valid), 128'(1));
        chk("pre_rst_busy", 128'(busy), 128'(1));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("post_rst_m_valid", 128'(m_valid), 128'(0));
        chk("post_rst_busy", 128'(busy), 128'(0));
        chk("post_rst_s_ready", 128'(s_ready), 128'(0));
        chk("post_rst_m_data", m_data, '0);
        flag = 1'b0;
        s_valid = 1'b1; s_data = FIPS_PT_A;
        for (int n = 0; n < 20; n++) begin
            flag |= m_valid | s_ready | busy;
            tick();
        end
        chk("post_rst_quiet", 128'(flag), 128'(0));
        key_load = 1'b1; key_in = FIPS_KEY_A;
        tick();
        key_load = 1'b0;
        chk("rekey_s_ready", 128'(s_ready), 128'(1));
        tick();
        s_valid = 1'b0;
        repeat (11) tick();
        chk("rekey_m_valid", 128'(m_valid), 128'(1));
        chk("rekey_m_data", m_data, FIPS_CT_A);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/aes_stream_ctrl.md
# aes_stream_ctrl

Streaming controller for the fully pipelined AES-128 encryptor, which has no valid or stall signals of its own. It accepts plaintext blocks on a valid/ready port and loads the round key. It tags each pipeline slot with a valid bit and captures ciphertext into an output FIFO. A credit scheme throttles input so that no result is dropped, because the AES pipeline cannot be stalled.

## Interface
- LATENCY, 10: AES pipeline depth in clocks, from the plaintext/key input to a valid ciphertext.
- FIFO_DEPTH, 16: output FIFO entries. Must be a power of 2 and at least LATENCY+1.
- clk  in  1  system clock. All logic is on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- key_load  in  1  when high, key_in is captured into the key register.
- key_in  in  128  AES-128 key.
- s_valid  in  1  plaintext valid.
- s_ready  out  1  controller can accept a plaintext block.
- s_data  in  128  plaintext block.
- m_valid  out  1  ciphertext valid (FIFO not empty).
- m_ready  in  1  downstream accepts the ciphertext.
- m_data  out  128  ciphertext at the FIFO head.
- busy  out  1  at least one block is in flight or in the FIFO.
- aes_key  out  128  drives the AES key input.
- aes_plaintext  out  128  drives the AES plaintext input.
- aes_ciphertext  in  128  AES ciphertext output.

## Operation
- An input handshake occurs when s_valid && s_ready.
- On a handshake, s_data is loaded into pt_reg (drives aes_plaintext) and tag[0] is set to 1.
- With no handshake, tag[0] is 0 and pt_reg holds its value (bubble; data is don't-care).
- key_reg drives aes_key.
- key_load loads key_reg and sets key_valid.
- If key_load and a handshake fall on the same edge, that block uses the new key_in. Every later block uses key_reg until the next key_load.
- Blocks with different keys may be in flight at the same time; the AES pipeline carries each key alongside its block.
- tag[LATENCY:0] shifts by one position every cycle, unconditionally.
- When tag[LATENCY] is 1, aes_ciphertext is written into the FIFO on that edge.
- inflight_cnt is the number of 1s in tag[LATENCY:0], kept as an up/down counter. It increments on a handshake and decrements on a FIFO write; both on the same edge leaves it unchanged.
- fifo_cnt: incremented on a write, decremented on a pop (m_valid && m_ready). A write and a pop on the same edge leave it unchanged.
- s_ready = key_valid && (inflight_cnt + fifo_cnt < FIFO_DEPTH), computed from registers only. There is no combinational path from m_ready to s_ready, so a pop frees its credit one cycle later.
- The credit check guarantees that a FIFO write never finds the FIFO full. An overflow is a design error; simulation must assert on it.
- Blocks leave in acceptance order.
- busy = (inflight_cnt != 0) || (fifo_cnt != 0).
- Reset while operating: all tags are cleared, the FIFO is emptied, key_valid is cleared and in-flight blocks are discarded.
- After reset, s_ready stays low until the first key_load.

## Timing
- Reset values: s_ready=0, m_valid=0, m_data=0, busy=0, aes_key=0, aes_plaintext=0.
- Handshake at edge E0:
  - pt_reg and tag[0] are loaded at E0.
  - AES stage k registers the block at E(k).
  - The ciphertext is valid after E(LATENCY) with tag[LATENCY] set.
  - The FIFO write occurs at E(LATENCY+1).
  - m_valid is high after E(LATENCY+1): 11 cycles of latency with an empty FIFO.
- Throughput is 1 block/clk when m_ready is held high, since FIFO_DEPTH ≥ LATENCY+1.
- m_data/m_valid come from registered FIFO state. m_data is stable while m_valid && !m_ready.
- key_load takes effect on the next edge; there is no pipeline drain.

## Structure
- aes_pkg holds:
  - the AES_LATENCY=10 constant;
  - the aes_block_t 128-bit typedef;
  - FIPS-197 test constants for the bench.
- The sub-module aes_out_fifo is a synchronous single-clock FIFO (FIFO_DEPTH × 128) with wr_en, rd_en, empty, count and a show-ahead head output.
- The controller contains the key/pt registers, the tag shift register, the counters and the credit logic.

## Test plan
- Reset, then key_load key=000102030405060708090a0b0c0d0e0f, then a single block 00112233445566778899aabbccddeeff -> m_valid exactly 11 cycles after the handshake, m_data=69c4e0d86a7b0430d8cdb78070b4c55a.
- s_valid high before any key_load -> s_ready stays 0 and busy=0. After key_load, s_ready=1 on the next cycle.
- 32 back-to-back blocks with m_ready=1 -> one result per cycle after the initial 11 cycles, in order, matching the reference model. s_ready is never deasserted.
- m_ready=0 with continuous s_valid -> exactly 16 blocks accepted, s_ready goes low and the FIFO holds 16 entries. Releasing m_ready drains them in order, and s_ready reasserts one cycle after the first pop.
- key_load key=2b7e151628aed2a6abf7158809cf4f3c on the same edge as the handshake for pt=3243f6a8885a308d313198a2e0370734, with the previous block using the old key -> that block gives 3925841d02dc09fbdc118597196a0b32, and the previous block's result is unaffected.
- rst_n low for 1 cycle with 5 blocks in flight and 3 in the FIFO -> no m_valid afterwards, busy=0, s_ready=0 until a new key_load.
